serial_cmp_feeder: RTL and testbench

//  Upstream stage of the bit-serial magnitude comparator. Accepts two parallel

---
 rtl/serial_cmp_feeder_if.sv | 27 ++
 rtl/serial_cmp_feeder.sv | 92 +++++++++
 tb/tb_serial_cmp_feeder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_cmp_feeder_if.sv
// Operand handshake, stall control and serial bit-pair outputs of the serial comparator feeder.
// slave modport is the feeder; master modport is the operand source and comparator side.
interface serial_cmp_feeder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic             stall;
  logic             cmp_clr;
  logic             a_bit;
  logic             b_bit;
  logic             last_bit;
  logic             busy;
  logic             done;

  modport slave (
    input  in_valid, a_word, b_word, stall,
    output in_ready, cmp_clr, a_bit, b_bit, last_bit, busy, done
  );

  modport master (
    output in_valid, a_word, b_word, stall,
    input  in_ready, cmp_clr, a_bit, b_bit, last_bit, busy, done
  );
endinterface

// File: rtl/serial_cmp_feeder.sv
// Shifts an accepted operand pair out LSB first to a bit-serial comparator; accepts one pair per WIDTH+3 cycles.
// Done is high WIDTH+2 cycles after the accepting cycle; stall freezes SHIFT, and in_ready is high only in IDLE.
module serial_cmp_feeder #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  serial_cmp_feeder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter saturates at LAST; it is only reloaded when a new pair is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sha <= '0;
      shb <= '0;
      cnt <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      sha <= bus.a_word;
      shb <= bus.b_word;
      cnt <= '0;
    end else if (state == SHIFT && !bus.stall) begin
      sha <= {1'b0, sha[WIDTH-1:1]};
      shb <= {1'b0, shb[WIDTH-1:1]};
      if (cnt != LAST) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Outputs decode from state and registers only, so none depends on in_valid.
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.cmp_clr  = 1'b0;
    bus.a_bit    = 1'b0;
    bus.b_bit    = 1'b0;
    bus.last_bit = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        bus.cmp_clr = 1'b1;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        bus.a_bit    = sha[0];
        bus.b_bit    = shb[0];
        bus.last_bit = (cnt == LAST);
        if (!bus.stall && cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_serial_cmp_feeder.sv
// Directed bench for serial_cmp_feeder: scoreboarded WIDTH=8 instance plus a WIDTH=2 instance.
module tb_serial_cmp_feeder;
  localparam int W = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         rel;     // 0 equal, 1 a greater, 2 a less
    int         stalls;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t sb[$];
  int   acc_q[$];
  int   accept_hist[$];

  int         idx;
  logic [7:0] ra, rb;
  int         rel_model;

  serial_cmp_feeder_if #(.WIDTH(8)) bus8();
  serial_cmp_feeder_if #(.WIDTH(2)) bus2();

  serial_cmp_feeder #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  serial_cmp_feeder #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: a bit-serial comparator model fed from the DUT, plus word reconstruction.
  always @(negedge clk) begin
    if (reset) begin
      idx = 0;
      ra = '0;
      rb = '0;
      rel_model = 0;
      acc_q.delete();
    end else begin
      if (bus8.in_valid && bus8.in_ready) begin
        acc_q.push_back(cyc);
        accept_hist.push_back(cyc);
      end
      if (bus8.cmp_clr) begin
        check("clr_bits", int'({bus8.a_bit, bus8.b_bit}), 0);
        check("clr_in_ready", int'(bus8.in_ready), 0);
        idx = 0;
        ra = '0;
        rb = '0;
        rel_model = 0;
      end else if (bus8.busy && !bus8.done) begin
        if (bus8.a_bit != bus8.b_bit) rel_model = bus8.a_bit ? 1 : 2;
        if (!bus8.stall) begin
          check("last_bit", int'(bus8.last_bit), int'(idx == W - 1));
          if (idx < W) begin
            ra[idx] = bus8.a_bit;
            rb[idx] = bus8.b_bit;
          end
          idx++;
        end
      end else if (bus8.done) begin
        n_tests++;
        assert (sb.size() > 0 && acc_q.size() > 0) else begin
          n_fail++;
          $error("FAIL done_unexpected: observed done pulse, required no pending pair");
        end
        if (sb.size() > 0 && acc_q.size() > 0) begin
          exp_t e;
          int   acc;
          e = sb.pop_front();
          acc = acc_q.pop_front();
          check("word_a", int'(ra), int'(e.a));
          check("word_b", int'(rb), int'(e.b));
          check("cmp_result", rel_model, e.rel);
          check("done_latency", cyc - acc, W + 2 + e.stalls);
          check("done_in_ready", int'(bus8.in_ready), 0);
        end
      end
    end
  end

  // Presents a pair and returns one cycle after it is accepted, leaving in_valid high.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input int stalls);
    exp_t e;
    int   n;
    e.a = a;
    e.b = b;
    e.rel = (a > b) ? 1 : ((a < b) ? 2 : 0);
    e.stalls = stalls;
    sb.push_back(e);
    bus8.a_word = a;
    bus8.b_word = b;
    bus8.in_valid = 1'b1;
    n = 0;
    while (!bus8.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", int'(n < 100), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] a2, b2;
    int         dc;
    reset = 1'b1;
    bus8.in_valid = 1'b0; bus8.a_word = '0; bus8.b_word = '0; bus8.stall = 1'b0;
    bus2.in_valid = 1'b0; bus2.a_word = '0; bus2.b_word = '0; bus2.stall = 1'b0;
    #1;
    check("rst_in_ready", int'(bus8.in_ready), 1);
    check("rst_outs", int'({bus8.cmp_clr, bus8.a_bit, bus8.b_bit, bus8.last_bit, bus8.busy, bus8.done}), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Equal operands
    send(8'hA5, 8'hA5, 0);
    bus8.in_valid = 1'b0;
    drain();

    // MSB decides against all lower bits
    send(8'h80, 8'h7F, 0);
    bus8.in_valid = 1'b0;
    drain();

    // Stall for 3 cycles while the second bit pair is presented
    send(8'h01, 8'h02, 3);
    bus8.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus8.stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_hold", int'({bus8.a_bit, bus8.b_bit}), 1);
    end
    bus8.stall = 1'b0;
    drain();

    // Back-to-back with in_valid held high
    accept_hist.delete();
    send(8'h3C, 8'hC3, 0);
    send(8'h55, 8'h54, 0);
    bus8.in_valid = 1'b0;
    drain();
    check("b2b_accepts", accept_hist.size(), 2);
    if (accept_hist.size() == 2)
      check("b2b_spacing", accept_hist[1] - accept_hist[0], W + 3);

    // Reset during the fifth shift bit aborts the pair without a done pulse
    send(8'h3C, 8'h11, 0);
    bus8.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("pre_abort_busy", int'(bus8.busy), 1);
    #2 reset = 1'b1;
    #1;
    check("abort_in_ready", int'(bus8.in_ready), 1);
    check("abort_outs", int'({bus8.cmp_clr, bus8.a_bit, bus8.b_bit, bus8.last_bit, bus8.busy, bus8.done}), 0);
    void'(sb.pop_back());
    @(negedge clk);
    #1 reset = 1'b0;
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) dc++;
    end
    check("abort_no_done", dc, 0);
    send(8'hFF, 8'h00, 0);
    bus8.in_valid = 1'b0;
    drain();

    // WIDTH=2 instance
    a2 = 2'b10;
    b2 = 2'b01;
    @(posedge clk); #1;
    check("w2_idle_ready", int'(bus2.in_ready), 1);
    bus2.a_word = a2;
    bus2.b_word = b2;
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    check("w2_clr", int'(bus2.cmp_clr), 1);
    @(posedge clk); #1;
    check("w2_bit0", int'({bus2.a_bit, bus2.b_bit, bus2.last_bit}), int'({a2[0], b2[0], 1'b0}));
    @(posedge clk); #1;
    check("w2_bit1", int'({bus2.a_bit, bus2.b_bit, bus2.last_bit}), int'({a2[1], b2[1], 1'b1}));
    @(posedge clk); #1;
    check("w2_done", int'(bus2.done), 1);
    @(posedge clk); #1;
    check("w2_back_idle", int'({bus2.done, bus2.in_ready}), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
